// File: rtl/mem_ctrl_if.sv
// Bus bundle between the core-side requesters (IF, MEM) and the
// byte-wide unified RAM on one side, and mem_ctrl on the other.
// The controller takes the slave view; the pipeline and RAM model take the master view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  // Instruction fetch port.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  // Load/store port fed from the EX/MEM pipeline register.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  // Byte-wide RAM port.
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    input  ram_din,
    output if_done, if_data,
    output mem_done, mem_rdata,
    output ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    output ram_din,
    input  if_done, if_data,
    input  mem_done, mem_rdata,
    input  ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller: arbitrates instruction fetch against
// MEM-stage loads/stores and sequences each access as back-to-back byte
// transfers on the byte-wide RAM. Results come back with a one-cycle done
// pulse. Every output is a flop.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic     clk,
  input logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [2:0]        cyc_q,       cyc_d;
  logic [2:0]        len_q,       len_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [31:0]       rbuf_q,      rbuf_d;
  logic [ADDR_W-1:0] ram_a_q,     ram_a_d;
  logic              ram_wr_q,    ram_wr_d;
  logic [7:0]        ram_dout_q,  ram_dout_d;
  logic              if_done_q,   if_done_d;
  logic              mem_done_q,  mem_done_d;
  logic [31:0]       if_data_q,   if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [1:0]        rd_idx;
  logic [31:0]       rd_merged;
  logic              accept_ok;

  // Byte counts other than 1 and 2 collapse to a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      3'd1:    norm_len = 3'd1;
      3'd2:    norm_len = 3'd2;
      default: norm_len = 3'd4;
    endcase
  endfunction

  // Read byte arriving on ram_din this cycle, merged into the assembly buffer.
  // ram_din lags ram_a by one cycle, so at cycle count j the byte belongs to lane j-2.
  always_comb begin
    rd_idx    = cyc_q[1:0] - 2'd2;
    rd_merged = rbuf_q | (32'(bus.ram_din) << {rd_idx, 3'b000});
    accept_ok = !if_done_q && !mem_done_q;
  end

  // Next-state logic: acceptance and arbitration in IDLE, then byte sequencing.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        cyc_d = 3'd0;
        if (accept_ok) begin
          if (bus.mem_req) begin
            ram_a_d = bus.mem_addr;
            len_d   = norm_len(bus.mem_len);
            wdata_d = bus.mem_wdata;
            rbuf_d  = 32'd0;
            cyc_d   = 3'd1;
            if (bus.mem_we) begin
              state_d    = MEM_WR;
              ram_wr_d   = 1'b1;
              ram_dout_d = bus.mem_wdata[7:0];
            end else begin
              state_d = MEM_RD;
            end
          end else if (bus.if_req) begin
            ram_a_d = bus.if_addr;
            len_d   = 3'd4;
            rbuf_d  = 32'd0;
            cyc_d   = 3'd1;
            state_d = IF_RD;
          end
        end
      end

      IF_RD, MEM_RD: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q < len_q) begin
          ram_a_d = ram_a_q + ADDR_W'(1);
        end
        if (cyc_q >= 3'd2) begin
          rbuf_d = rd_merged;
        end
        if (cyc_q == len_q + 3'd1) begin
          state_d = IDLE;
          cyc_d   = 3'd0;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_data_d = rd_merged;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rd_merged;
          end
        end
      end

      MEM_WR: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q < len_q) begin
          ram_a_d    = ram_a_q + ADDR_W'(1);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
        end else begin
          mem_done_d = 1'b1;
          state_d    = IDLE;
          cyc_d      = 3'd0;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 3'd0;
      end
    endcase
  end

  // State, counters and all registered outputs; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 3'd0;
      len_q       <= 3'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller between the core pipeline and the byte-wide unified RAM.
- Arbitrates between instruction fetch (IF, always 4-byte reads) and the MEM stage (1/2/4-byte loads and stores, fed from the EX/MEM pipeline register).
- Sequences every multi-byte access as consecutive byte transfers and returns results with a one-cycle done pulse; requesters hold the pipeline stalled until done.

Parameters:
- ADDR_W, 32, address width of requester and RAM address ports.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  base byte address
- mem_len  in  3  byte count: 1, 2 or 4 (other values are treated as 4)
- mem_wdata  in  32  store data, byte k = bits [8k+7:8k]
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load result, zero-extended (sign extension is done in MEM)
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; carries data for the ram_a presented in the previous cycle

Behaviour:
- All outputs are registered.
- Reset values: ram_a=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, FSM=IDLE, byte counter=0.
- FSM states:
  - IDLE: no transfer in progress.
  - IF_RD: fetch read in progress.
  - MEM_RD: load in progress.
  - MEM_WR: store in progress.
- Acceptance (IDLE, rising edge):
  - If mem_req=1, latch mem_addr, mem_len and mem_wdata, then go to MEM_WR if mem_we=1, else MEM_RD.
  - Else if if_req=1, latch if_addr with len=4 and go to IF_RD.
  - MEM always wins a simultaneous request; this prevents deadlock, since MEM is the older instruction.
  - No acceptance in a cycle where if_done or mem_done is high. This gives a one-cycle gap so a requester that has just finished can drop its req.
- No preemption: a request arriving mid-transfer waits until the current transfer completes plus the gap cycle.
- Reads (latency N+2 from the acceptance edge E0):
  - Cycle k+1 (k=0..N-1): ram_a = base+k, ram_wr=0.
  - Byte k is sampled from ram_din at edge E(k+2) into bits [8k+7:8k].
  - Bits above 8N are zero.
  - done and data are asserted in cycle N+2, then the FSM returns to IDLE.
- Writes (latency N+1 from E0):
  - Cycle k+1: ram_a = base+k, ram_wr=1, ram_dout = byte k.
  - Cycle N+1: ram_wr=0 and mem_done=1.
- Address arithmetic is modulo 2^ADDR_W, so the byte address wraps from all-ones to 0. Unaligned base addresses are legal.
- In IDLE: ram_wr=0, and ram_a holds its last value.
- if_data and mem_rdata hold their values until the next completion of the same port.
- Reset mid-transfer:
  - The transfer is abandoned and outputs return to reset values on the next edge.
  - A partially written store remains in RAM as written.
  - No done pulse is issued.
- A requester dropping req mid-transfer is not supported; the controller completes the access regardless.

Test Plan:
- Reset then idle: hold rst 2 cycles with both reqs high -> ram_wr=0, both dones 0. The first acceptance happens on the first edge after rst falls.
- IF fetch: RAM[0x100..0x103]=0x13,0x05,0x00,0x00; if_req, if_addr=0x100 -> ram_a 0x100..0x103 in cycles 1-4, if_done in cycle 6 with if_data=0x00000513.
- Byte/half load:
  - mem_len=1 at 0x203 with RAM=0xFF -> mem_done in cycle 3, mem_rdata=0x000000FF.
  - mem_len=2 at 0x1FFF -> ram_a 0x1FFF then 0x2000.
- Word store: mem_we=1, addr 0x40, wdata=0xDEADBEEF -> ram_wr=1 with (0x40,0xEF), (0x41,0xBE), (0x42,0xAD), (0x43,0xDE), mem_done in cycle 5. A read-back via IF returns 0xDEADBEEF.
- Simultaneous requests: if_req and mem_req rise together -> MEM is served first, a one-cycle gap follows mem_done, then IF is accepted. Also: mem_req arriving during IF_RD waits until after if_done.
- Reset mid-store: assert rst in cycle 2 of a 4-byte store -> only bytes 0-1 are written, no mem_done, FSM in IDLE, ram_wr=0 on the next edge.
- Address wrap: a 4-byte read at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
